// File: rtl/digit_pkg.sv
// digit_pkg: shared definitions for the decimal digit unit.
//   op_e     : request opcode (OP_DGT extracts a digit, OP_DST sets a digit)
//   state_e  : sequencing FSM states of digit_unit_seq
//   pow10(i) : 10^i as an elaboration-time constant, used for the shift-add
//              digit weights and for MAXVAL
package digit_pkg;

  typedef enum logic {
    OP_DGT = 1'b0,
    OP_DST = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int unsigned pow10(input int unsigned i);
    int unsigned p;
    p = 1;
    for (int unsigned k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_serial_conv.sv
// bcd_serial_conv: serial double-dabble binary-to-BCD converter.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load bin and clear the BCD register (one-cycle pulse)
//   bin        : unsigned binary value, must be <= 10^DIGITS-1
//   bcd        : packed BCD result, digit i at bcd[4*i +: 4]
//   done       : high once all W bits have been shifted, until next start
// One add-3-then-shift step per cycle; W steps after start.
module bcd_serial_conv
  import digit_pkg::*;
#(
  parameter int W      = 11,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  logic [CNT_W-1:0]     cnt;
  logic                 busy;
  logic [W-1:0]         bin_sr;
  logic [BCD_W-1:0]     bcd_q;
  logic [BCD_W+W-1:0]   shift_nxt;

  // Any nibble >= 5 would overflow past 9 when doubled; pre-add 3 so the
  // carry lands in the next decimal digit after the shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign shift_nxt = {add3(bcd_q), bin_sr} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      done <= 1'b0;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(W - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      bin_sr <= bin;
      bcd_q  <= '0;
    end else if (busy) begin
      {bcd_q, bin_sr} <= shift_nxt;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/digit_unit_seq.sv
// digit_unit_seq: multi-cycle decimal digit unit (DGT extract / DST set)
// on signed accumulators of DIGITS decimal digits.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake; ready only while idle
//   req_op              : 0 = DGT, 1 = DST
//   req_acc             : signed accumulator (magnitude saturates to MAXVAL)
//   req_arg1            : signed digit index, 0 = units, negative = out of range
//   req_arg2            : new digit value for DST, clamped to 0..9
//   rsp_valid/rsp_ready : response handshake; rsp_data held until accepted
//   rsp_data            : signed result
//   rsp_err             : only with DIGIT_UNIT_ERR_EN defined; flags index out
//                         of range, clamped digit or saturated accumulator
// Optional feature macro: DIGIT_UNIT_ERR_EN.
// Response appears W+2 cycles after the accepting edge.
module digit_unit_seq
  import digit_pkg::*;
#(
  parameter int W      = 11,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_op,
  input  logic signed [W-1:0] req_acc,
  input  logic signed [W-1:0] req_arg1,
  input  logic signed [W-1:0] req_arg2,
  output logic                rsp_valid,
  input  logic                rsp_ready,
`ifdef DIGIT_UNIT_ERR_EN
  output logic                rsp_err,
`endif
  output logic signed [W-1:0] rsp_data
);

  localparam int MAXVAL = int'(pow10(DIGITS)) - 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BCD_W  = 4 * DIGITS;

  state_e               state, state_nxt;
  logic                 accept;
  logic                 arg1_ok;
  logic [W:0]           acc_abs;
  logic [W-1:0]         acc_mag;
  logic                 conv_done;
  logic [BCD_W-1:0]     bcd;

  op_e                  op_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 oor_q;
  logic [3:0]           arg2_q;
  logic                 sign_q;
  logic [W-1:0]         mag_q;

  logic [W:0]           sum;
  logic [3:0]           sel;
  logic [3:0]           d;
  logic [W-1:0]         res_mag;
  logic signed [W-1:0]  calc_res;

  // |v| in W+1 bits so the most negative input does not wrap.
  function automatic logic [W:0] abs_ext(input logic signed [W-1:0] v);
    if (v[W-1]) return {1'b0, ~v} + (W+1)'(1);
    return {1'b0, v};
  endfunction

  function automatic logic [W-1:0] sat_mag(input logic [W:0] a);
    if (a > (W+1)'(MAXVAL)) return W'(MAXVAL);
    return a[W-1:0];
  endfunction

  function automatic logic [3:0] clamp_digit(input logic signed [W-1:0] v);
    if (v[W-1]) return 4'd0;
    if ($unsigned(v) > W'(9)) return 4'd9;
    return v[3:0];
  endfunction

  assign accept  = (state == IDLE) && req_valid;
  assign arg1_ok = !req_arg1[W-1] && ($unsigned(req_arg1) < W'(DIGITS));
  assign acc_abs = abs_ext(req_acc);
  assign acc_mag = sat_mag(acc_abs);

  // Capture on accept; the converter is loaded on the same edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op_e'(req_op);
      idx_q  <= req_arg1[IDX_W-1:0];
      oor_q  <= !arg1_ok;
      arg2_q <= clamp_digit(req_arg2);
      sign_q <= req_acc[W-1];
      mag_q  <= acc_mag;
    end
  end

`ifdef DIGIT_UNIT_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (accept)
      err_q <= !arg1_ok || req_arg2[W-1] || ($unsigned(req_arg2) > W'(9))
               || (acc_abs > (W+1)'(MAXVAL));
  end

  assign rsp_err = err_q;
`endif

  bcd_serial_conv #(
    .W      (W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .bin   (acc_mag),
    .bcd   (bcd),
    .done  (conv_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = CONV;
      CONV:    if (conv_done) state_nxt = CALC;
      CALC:    state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result: digit weights are constants, so each product is a shift-add.
  // Magnitude is at most MAXVAL, so a zero magnitude negates to zero.
  always_comb begin
    sum = '0;
    sel = '0;
    d   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = bcd[4*i +: 4];
      if (!oor_q && (idx_q == IDX_W'(i))) begin
        sel = d;
        if (op_q == OP_DST) d = arg2_q;
      end
      sum = sum + (W+1)'(d) * (W+1)'(pow10(i));
    end
    if (oor_q) res_mag = (op_q == OP_DST) ? mag_q : '0;
    else       res_mag = (op_q == OP_DST) ? W'(sum) : W'(sel);
    calc_res = sign_q ? -$signed(res_mag) : $signed(res_mag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rsp_data <= '0;
    else if (state == CALC)  rsp_data <= calc_res;
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);

endmodule

// File: doc/digit_unit_seq.md
Name: digit_unit_seq

Overview:
- Multi-cycle decimal digit unit for the ALU; successor to the single-cycle digit-set logic.
- Executes DGT (extract digit) and DST (set digit) on signed accumulators of DIGITS decimal digits.
- Uses a serial binary-to-BCD converter, so no wide combinational BCD tree is needed.
- Sits beside the ALU behind a valid/ready request/response pair; the ALU sequencer stalls on req_ready and rsp_valid.

Parameters:
- W, 11, signed data width of acc, arg1, arg2 and result; must hold ±(10^DIGITS-1).
- DIGITS, 3, number of decimal digits addressable; MAXVAL = 10^DIGITS-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, request accepted when valid&&ready.
- req_op  in  1  0 = DGT, 1 = DST.
- req_acc  in  W  signed accumulator.
- req_arg1  in  W  signed digit index (0 = units).
- req_arg2  in  W  signed new digit value (DST only).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  W  signed result.

Behaviour:
- Reset, asynchronous, active-low, usable at any time:
  - req_ready=1, rsp_valid=0, rsp_data=0, FSM in IDLE.
  - Any in-flight operation is discarded and no response is emitted.
- Operand capture on accept (IDLE && req_valid):
  - Register op, arg1 and arg2.
  - Register sign = (acc<0).
  - Register mag = min(|acc|, MAXVAL); the input saturates.
  - Clamp arg2 to the range 0..9.
- FSM:
  - IDLE -> CONV on accept.
  - CONV: one double-dabble shift per cycle for exactly W cycles, with a cycle counter 0..W-1. Then -> CALC.
  - CALC: one cycle; compute and register rsp_data. Then -> DONE.
  - DONE: rsp_valid=1. On rsp_ready -> IDLE, and rsp_valid drops next cycle.
- Latency: rsp_valid rises W+2 cycles after the accepting edge (13 cycles at default).
- req_ready=1 only in IDLE. No pipelining; the unit holds one operation at a time.
- rsp_data stays stable in DONE until the handshake completes. It holds its last value afterwards.
- DGT:
  - If 0<=arg1<DIGITS: result = digit[arg1], negated when sign=1.
  - Otherwise: result = 0.
- DST:
  - If 0<=arg1<DIGITS: digit[arg1] is replaced by arg2, then result = Σ digit[i]·10^i, negated when sign=1.
  - Otherwise: result = sign ? -mag : mag (accumulator unchanged apart from saturation).
- Zero magnitude always yields result 0 (no negative zero).
- A negative arg1 counts as out of range.
- Arithmetic: the BCD register is 4·DIGITS bits wide. Multiplies by 10^i use shift-add constants. The intermediate sum is held in W+1 bits, then truncated to W bits; the result can never exceed MAXVAL.

Optional Feature:
- Macro: DIGIT_UNIT_ERR_EN.
- Defined:
  - Adds output port rsp_err (1 bit, reset 0), valid together with rsp_valid.
  - rsp_err is set when arg1 was out of range, arg2 was clamped, or acc was saturated.
- Undefined:
  - The port is absent and the same cases resolve silently as described in Behaviour.

Decomposition:
- Package digit_pkg:
  - Op encodings OP_DGT and OP_DST.
  - FSM state enum (IDLE, CONV, CALC, DONE).
  - Function returning 10^i as a constant for i < DIGITS.
- Sub-module bcd_serial_conv:
  - Inputs: start, bin[W-1:0].
  - Outputs: bcd[4·DIGITS-1:0], done.
  - Add-3-then-shift, one bit per cycle.
  - Owned by the CONV state.

Test Plan:
- DST, acc=567, arg1=1, arg2=2 -> rsp_data=527, rsp_valid exactly 13 cycles after accept. Same with acc=-567 -> -527.
- DGT, acc=-567, arg1=2 -> -5. DGT, acc=40, arg1=0 -> 0. DGT, acc=567, arg1=3 -> 0.
- DST, acc=567, arg1=-1, arg2=4 -> 567. DST, acc=1023, arg1=0, arg2=12 -> 999 (saturated, then digit clamped to 9). With DIGIT_UNIT_ERR_EN, rsp_err=1 in both cases.
- DST, acc=-5, arg1=0, arg2=0 -> 0 (no negative zero).
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles: rsp_data stable, req_ready=0 throughout.
  - Raise rsp_ready: IDLE next cycle, and a back-to-back request is accepted then.
- Drop rst_n in the middle of CONV (cycle 4): outputs return to their reset values immediately, no response is emitted, and a new request after reset completes correctly.
